// File: rtl/sd_rx_pack_fifo.sv
// sd_rx_pack_fifo
// Receive packing FIFO for the SD controller data path. DAT-line beats of
// 1, 4 or 8 bits arrive in the card clock domain (wclk). They are packed
// into DATA_W-bit words in a selectable byte order and buffered in a
// dual-clock FIFO that the bus side reads in the rclk domain.
//
// Ports
//   wclk, rclk      write (card) and read (bus) clocks
//   rst             asynchronous active-high reset, clears both domains
//   bus_mode        0 = 1-bit, 1 = 4-bit, 2 = 8-bit, 3 = treated as 4-bit
//   big_endian      1: first beat lands in the word MSBs, 0: in the LSBs
//   d, wr           beat data and beat strobe
//   flush           commit the partial word, zero-padded
//   full, overflow  writer-side flags (overflow is sticky until rst)
//   wr_level        words stored, as seen by the writer
//   q, rd, empty    first-word-fall-through head word, pop, empty flag
//   rd_level        words stored, as seen by the reader
//
// Handshake: wr is a plain strobe. Each wclk edge with wr=1 takes one beat
// and there is no back-pressure. A word that completes while full=1 is
// dropped and overflow is set. rd is a pop request, and it only takes
// effect on an rclk edge where empty=0. q is valid whenever empty=0.
module sd_rx_pack_fifo #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  rclk,
  input  logic [1:0]            bus_mode,
  input  logic                  big_endian,
  input  logic [7:0]            d,
  input  logic                  wr,
  input  logic                  flush,
  output logic                  full,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   wr_level,
  output logic [DATA_W-1:0]     q,
  input  logic                  rd,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   rd_level
);

  localparam int P     = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  // The counter must hold DATA_W-1 plus one 8-bit beat. A bus_mode change
  // mid-word can overshoot DATA_W, and the overshoot must not wrap.
  localparam int CW    = $clog2(DATA_W + 8);
  localparam logic [CW-1:0] DW_C      = CW'(DATA_W);
  localparam logic [P-1:0]  FULL_MASK = P'(3) << (P - 2);

  function automatic logic [P-1:0] bin2gray(input logic [P-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
    logic [P-1:0] b;
    b[P-1] = g[P-1];
    for (int i = P - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- wclk side
  logic                  r_wrun;
  logic [DATA_W-1:0]     r_shift;
  logic [CW-1:0]         r_bcnt;
  logic [P-1:0]          r_wptr;
  logic [P-1:0]          r_wgray;
  logic [SYNC_STAGES-1:0][P-1:0] r_rsync;
  logic                  r_full;
  logic                  r_overflow;

  logic                  w_wr_ok;
  logic                  w_fl_ok;
  logic [CW-1:0]         w_bw;
  logic [7:0]            w_beat;
  logic [DATA_W-1:0]     w_beat_ext;
  logic [DATA_W-1:0]     w_ins;
  logic [DATA_W-1:0]     w_word_nx;
  logic [CW-1:0]         w_bcnt_nx;
  logic                  w_commit;
  logic                  w_push;
  logic [P-1:0]          w_wptr_nx;

  // The reset release is registered once per domain. The first beat is then
  // accepted on the second wclk edge after rst falls.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) r_wrun <= 1'b0;
    else     r_wrun <= 1'b1;
  end

  assign w_wr_ok = wr & r_wrun;
  assign w_fl_ok = flush & r_wrun;

  always_comb begin
    w_bw   = CW'(4);
    w_beat = {4'b0, d[3:0]};
    case (bus_mode)
      2'd0: begin w_bw = CW'(1); w_beat = {7'b0, d[0]}; end
      2'd2: begin w_bw = CW'(8); w_beat = d;            end
      default: ;
    endcase
  end

  always_comb begin
    w_beat_ext      = '0;
    w_beat_ext[7:0] = w_beat;
  end

  // Big-endian parks the beat at the MSB end and then moves it down by
  // bcnt. Little-endian moves it up by bcnt.
  assign w_ins = big_endian ? ((w_beat_ext << (DW_C - w_bw)) >> r_bcnt)
                            : (w_beat_ext << r_bcnt);

  assign w_word_nx = w_wr_ok ? (r_shift | w_ins) : r_shift;
  assign w_bcnt_nx = w_wr_ok ? (r_bcnt + w_bw) : r_bcnt;

  // A flush on the edge that also completes a word yields that word once.
  assign w_commit  = (w_wr_ok && (w_bcnt_nx >= DW_C)) ||
                     (w_fl_ok && (w_bcnt_nx != '0));
  assign w_push    = w_commit & ~r_full;
  assign w_wptr_nx = r_wptr + P'(w_push);

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_wptr     <= '0;
      r_wgray    <= '0;
      r_rsync    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_commit) begin
        r_shift <= '0;
        r_bcnt  <= '0;
      end else if (w_wr_ok) begin
        r_shift <= w_word_nx;
        r_bcnt  <= w_bcnt_nx;
      end
      r_wptr     <= w_wptr_nx;
      r_wgray    <= bin2gray(w_wptr_nx);
      r_rsync    <= {r_rsync[SYNC_STAGES-2:0], r_rgray};
      // full is computed from the pointer after this edge. It therefore
      // rises on the edge that writes the last free slot.
      r_full     <= (bin2gray(w_wptr_nx) == (r_rsync[SYNC_STAGES-1] ^ FULL_MASK));
      r_overflow <= r_overflow | (w_commit & r_full);
    end
  end

  always_ff @(posedge wclk) begin
    if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= w_word_nx;
  end

  assign full     = r_full;
  assign overflow = r_overflow;
  assign wr_level = r_wptr - gray2bin(r_rsync[SYNC_STAGES-1]);

  // ---------------------------------------------------------------- rclk side
  logic                  r_rrun;
  logic [P-1:0]          r_rptr;
  logic [P-1:0]          r_rgray;
  logic [SYNC_STAGES-1:0][P-1:0] r_wsync;
  logic                  r_empty;

  logic                  w_pop;
  logic [P-1:0]          w_rptr_nx;

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) r_rrun <= 1'b0;
    else     r_rrun <= 1'b1;
  end

  assign w_pop     = rd & ~r_empty & r_rrun;
  assign w_rptr_nx = r_rptr + P'(w_pop);

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_rgray <= '0;
      r_wsync <= '0;
      r_empty <= 1'b1;
    end else begin
      r_rptr  <= w_rptr_nx;
      r_rgray <= bin2gray(w_rptr_nx);
      r_wsync <= {r_wsync[SYNC_STAGES-2:0], r_wgray};
      r_empty <= (bin2gray(w_rptr_nx) == r_wsync[SYNC_STAGES-1]);
    end
  end

  assign q        = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign empty    = r_empty;
  assign rd_level = gray2bin(r_wsync[SYNC_STAGES-1]) - r_rptr;

endmodule

// File: tb/tb_sd_rx_pack_fifo.sv
module tb_sd_rx_pack_fifo;

  localparam int DATA_W      = 32;
  localparam int DEPTH_LOG2  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 16;

  // ------------------------------------------------------ clock / reset
  logic wclk = 1'b0;
  logic rclk = 1'b0;
  logic rst  = 1'b1;

  initial forever #10 wclk = ~wclk;          // 50 MHz
  initial begin
    #7;
    forever #15 rclk = ~rclk;                // 33 MHz, edges never coincide with wclk
  end

  logic [1:0]            bus_mode   = 2'd1;
  logic                  big_endian = 1'b1;
  logic [7:0]            d          = '0;
  logic                  wr         = 1'b0;
  logic                  flush      = 1'b0;
  logic                  rd         = 1'b0;
  logic                  full;
  logic                  overflow;
  logic [DEPTH_LOG2:0]   wr_level;
  logic [DATA_W-1:0]     q;
  logic                  empty;
  logic [DEPTH_LOG2:0]   rd_level;

  sd_rx_pack_fifo #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .wclk(wclk), .rst(rst), .rclk(rclk),
    .bus_mode(bus_mode), .big_endian(big_endian), .d(d), .wr(wr), .flush(flush),
    .full(full), .overflow(overflow), .wr_level(wr_level),
    .q(q), .rd(rd), .empty(empty), .rd_level(rd_level)
  );

  // ------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  int rclk_cnt = 0;
  int last_wr_rcnt = 0;

  always @(posedge rclk) rclk_cnt++;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------ drivers
  task automatic drive_beat(input logic [7:0] dd, input logic fl);
    @(negedge wclk);
    wr = 1'b1; d = dd; flush = fl;
  endtask

  task automatic idle_w();
    @(negedge wclk);
    wr = 1'b0; flush = 1'b0; d = '0;
  endtask

  task automatic flush_only();
    @(negedge wclk);
    wr = 1'b0; flush = 1'b1;
    idle_w();
  endtask

  // The beats are split out of the intended word. The first beat is taken
  // from the MSB end in big-endian mode and from the LSB end otherwise.
  task automatic send_word(input logic [1:0] mode, input logic be,
                           input logic [31:0] word, input logic fl_last);
    int bw;
    int n;
    logic [31:0] tmp;
    logic [7:0]  beat;
    bw = (mode == 2'd0) ? 1 : (mode == 2'd2) ? 8 : 4;
    n  = 32 / bw;
    @(negedge wclk);
    wr = 1'b0; bus_mode = mode; big_endian = be;
    for (int k = 0; k < n; k++) begin
      tmp  = be ? (word >> (32 - bw * (k + 1))) : (word >> (bw * k));
      beat = tmp[7:0] & 8'((1 << bw) - 1);
      drive_beat(beat, fl_last && (k == n - 1));
    end
    @(posedge wclk);
    last_wr_rcnt = rclk_cnt;
    idle_w();
  endtask

  task automatic read_word(input string tag);
    int n;
    n = 0;
    @(negedge rclk);
    while (empty !== 1'b0 && n < 3000) begin
      @(negedge rclk);
      n++;
    end
    if (empty !== 1'b0) begin
      check_val({tag, "_timeout"}, 64'(empty), 64'd0);
      return;
    end
    if (exp_q.size() == 0) check_val({tag, "_unexpected"}, 64'(rd_level), 64'd0);
    else                   check_val(tag, 64'(q), 64'(exp_q.pop_front()));
    rd = 1'b1;
    @(negedge rclk);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wr = 1'b0; flush = 1'b0; rst = 1'b1;
    repeat (3) @(negedge wclk);
    rst = 1'b0;
    repeat (4) @(negedge wclk);
    repeat (4) @(negedge rclk);
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge wclk);
    check_val({tag, "_full"},     64'(full),     64'd0);
    check_val({tag, "_overflow"}, 64'(overflow), 64'd0);
    check_val({tag, "_wr_level"}, 64'(wr_level), 64'd0);
    @(negedge rclk);
    check_val({tag, "_empty"},    64'(empty),    64'd1);
    check_val({tag, "_rd_level"}, 64'(rd_level), 64'd0);
  endtask

  // ------------------------------------------------------ watchdog
  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ------------------------------------------------------ main sequence
  initial begin
    int t;
    int lat;
    logic [31:0] v;

    do_reset();
    check_reset_vals("reset");

    // The word must appear SYNC_STAGES+1 rclk edges after its write edge.
    exp_q.push_back(32'h12345678);
    send_word(2'd1, 1'b1, 32'h12345678, 1'b0);
    check_val("wr_level_one", 64'(wr_level), 64'd1);
    t = 0;
    while (empty !== 1'b0 && t < 50) begin @(negedge rclk); t++; end
    lat = rclk_cnt - last_wr_rcnt;
    check_val("empty_latency", 64'(lat), 64'(SYNC_STAGES + 1));
    check_val("rd_level_one", 64'(rd_level), 64'd1);
    read_word("be4_q");
    check_val("empty_after_pop", 64'(empty), 64'd1);

    exp_q.push_back(32'h87654321);
    send_word(2'd1, 1'b0, 32'h87654321, 1'b0);
    read_word("le4_q");

    exp_q.push_back(32'hA55AFF00);
    send_word(2'd2, 1'b1, 32'hA55AFF00, 1'b0);
    read_word("be8_q");

    exp_q.push_back(32'hAAAAAAAA);
    send_word(2'd0, 1'b1, 32'hAAAAAAAA, 1'b0);
    read_word("be1_q");

    // Flush cases: a partial word, a flush on the completing beat, a flush
    // together with a partial beat, and a flush with nothing pending.
    bus_mode = 2'd1; big_endian = 1'b1;
    drive_beat(8'h9, 1'b0);
    drive_beat(8'hC, 1'b0);
    drive_beat(8'h3, 1'b0);
    idle_w();
    flush_only();
    exp_q.push_back(32'h9C300000);
    exp_q.push_back(32'hDEADBEEF);
    send_word(2'd1, 1'b1, 32'hDEADBEEF, 1'b1);
    drive_beat(8'h7, 1'b0);
    drive_beat(8'h1, 1'b1);
    idle_w();
    exp_q.push_back(32'h71000000);
    flush_only();
    repeat (3) read_word("flush_q");
    repeat (8) @(negedge rclk);
    check_val("flush_empty", 64'(empty), 64'd1);
    check_val("flush_rd_level", 64'(rd_level), 64'd0);

    // Fill, overflow, drain through the pointer wrap.
    repeat (12) @(negedge wclk);
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      exp_q.push_back(v);
      send_word(2'd2, 1'b0, v, 1'b0);
      if (i == DEPTH - 2) check_val("full_before_last", 64'(full), 64'd0);
    end
    check_val("full_at_depth", 64'(full), 64'd1);
    check_val("wr_level_depth", 64'(wr_level), 64'(DEPTH));
    check_val("overflow_before", 64'(overflow), 64'd0);
    send_word(2'd2, 1'b0, 32'h13572468, 1'b0);
    check_val("overflow_set", 64'(overflow), 64'd1);
    check_val("wr_level_kept", 64'(wr_level), 64'(DEPTH));
    repeat (6) @(negedge rclk);
    check_val("rd_level_depth", 64'(rd_level), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) read_word("wrap_q");
    check_val("wrap_empty", 64'(empty), 64'd1);
    repeat (6) @(negedge wclk);
    check_val("full_cleared", 64'(full), 64'd0);
    check_val("wr_level_zero", 64'(wr_level), 64'd0);
    check_val("overflow_sticky", 64'(overflow), 64'd1);

    // Random stream with random modes and reader gaps.
    fork
      begin
        logic [1:0] m;
        logic [31:0] w;
        for (int i = 0; i < 1000; i++) begin
          t = 0;
          while (full === 1'b1 && t < 5000) begin @(negedge wclk); t++; end
          if (full !== 1'b0) check_val("stream_full_timeout", 64'(full), 64'd0);
          m = ($urandom_range(0, 5) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
          w = $urandom;
          exp_q.push_back(w);
          send_word(m, 1'($urandom_range(0, 1)), w, 1'b0);
          repeat ($urandom_range(0, 2)) @(negedge wclk);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          read_word("stream_q");
          repeat ($urandom_range(0, 3)) @(negedge rclk);
          if (i % 100 == 50) repeat (60) @(negedge rclk);
        end
      end
    join
    check_val("stream_drained", 64'(exp_q.size()), 64'd0);
    repeat (6) @(negedge rclk);
    check_val("stream_empty", 64'(empty), 64'd1);
    check_val("overflow_still", 64'(overflow), 64'd1);

    // Reset in mid-stream. Stored words and a partial word are discarded.
    for (int i = 0; i < 3; i++) send_word(2'd1, 1'b1, $urandom, 1'b0);
    drive_beat(8'h5, 1'b0);
    drive_beat(8'h6, 1'b0);
    do_reset();
    check_reset_vals("midrst");
    exp_q.delete();
    exp_q.push_back(32'hCAFEF00D);
    exp_q.push_back(32'h0BADBEEF);
    send_word(2'd1, 1'b1, 32'hCAFEF00D, 1'b0);
    send_word(2'd2, 1'b0, 32'h0BADBEEF, 1'b0);
    read_word("restart_q");
    read_word("restart_q");
    check_val("restart_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_rx_pack_fifo.md
# sd_rx_pack_fifo

Parametrised receive packing FIFO for the SD card controller data path. Collects 1-, 4- or 8-bit DAT-line beats in the card clock domain (wclk), packs them into DATA_W-bit words in a selectable byte order and buffers them in a dual-clock FIFO read by the host/bus side (rclk). Successor to the fixed 4-bit, 32-bit, single-order RX FIFO. Adds runtime bus-width and endian selection, parametrised depth, gray-code pointer synchronisation, partial-word flush, fill levels and a sticky overflow flag.

## Interface
- DATA_W, 32: output word width; multiple of 8, 8..64.
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 words.
- SYNC_STAGES, 2: flip-flop stages per pointer synchroniser, 2..4.
- wclk  in  1  write/card-side clock.
- rst  in  1  reset, asynchronous, active-high; clears both clock domains.
- rclk  in  1  read/bus-side clock.
- bus_mode  in  2  wclk domain: 0 = 1-bit (d[0]), 1 = 4-bit (d[3:0]), 2 = 8-bit (d[7:0]), 3 = reserved, treated as 4-bit.
- big_endian  in  1  wclk domain: 1 = first beat lands in word MSBs; 0 = first beat lands in LSBs.
- d  in  8  beat data; unused upper bits ignored.
- wr  in  1  beat strobe, one beat per wclk with wr=1.
- flush  in  1  wclk: commit partial word zero-padded, then clear packer.
- full  out  1  wclk domain: no free word slot.
- overflow  out  1  wclk domain, sticky: a completed word was dropped; cleared only by rst.
- wr_level  out  DEPTH_LOG2+1  wclk domain: words stored, as seen by the writer.
- rclk-side: q  out  DATA_W  head word, first-word-fall-through.
- rd  in  1  pop head word.
- empty  out  1  rclk domain.
- rd_level  out  DEPTH_LOG2+1  rclk domain: words stored, as seen by the reader.

## Operation
- Packer: shift/position register of DATA_W bits plus bit counter bcnt (0..DATA_W). Each wr beat adds w = 1/4/8 bits. Big-endian: beat k occupies bits [DATA_W-1-k*w -: w]. Little-endian: bits [k*w +: w].
- Word completes when bcnt+w == DATA_W. The completed word, including the current beat, is written to RAM on the same wclk edge and bcnt returns to 0.
- Completed word while full=1: not written, pointer unchanged, overflow set, packer cleared.
- flush=1: if bcnt>0 (after including a same-cycle wr beat), the partial word is written with unfilled positions 0, subject to the same full/overflow rule, and bcnt is cleared. If bcnt=0 and no beat is pending, nothing happens. If wr completes a word on the same edge, that word is written once; no extra empty word.
- bus_mode and big_endian may change only while bcnt=0. A change with bcnt>0 produces undefined packed data but must not corrupt pointers.
- Pointers: binary wptr/rptr, DEPTH_LOG2+1 bits with a wrap bit. Each pointer is converted to gray code, registered, and synchronised into the other domain through SYNC_STAGES flops.
- full when wptr gray == sync'd rptr gray with the two MSBs inverted. empty when rptr gray == sync'd wptr gray.
- Levels are computed modulo 2**(DEPTH_LOG2+1): wr_level = wptr − bin(sync rptr); rd_level = bin(sync wptr) − rptr. Range 0..DEPTH.
- Read: rd=1 with empty=0 advances rptr. rd while empty is ignored. q = ram[rptr[DEPTH_LOG2-1:0]]; it is valid whenever empty=0.

## Timing
- Reset values: full=0, overflow=0, wr_level=0, empty=1, rd_level=0, q undefined (RAM not reset). bcnt=0, pointers=0.
- rst asserted mid-word discards the partial word and all stored words. Deassertion is synchronised per domain, so the first accepted beat/rd comes on the second edge after release.
- Write-to-read latency: empty falls SYNC_STAGES+1 rclk edges after the wclk edge that writes the word.
- Read-to-free latency: full falls SYNC_STAGES+1 wclk edges after the popping rclk edge.
- full and empty are pessimistic, never optimistic. The writer never overwrites an unread word. The reader never pops an unwritten one.
- full asserts on the same wclk edge that writes the DEPTH-th word. empty asserts on the rclk edge that pops the last visible word.
- Pointer wrap: after 2**DEPTH_LOG2 words the RAM index returns to 0 and the wrap bit toggles. No data loss at wrap.

## Test plan
- 4-bit big-endian, DATA_W=32, nibbles 1,2,…,8 -> one word q=32'h12345678, empty falls after 3 rclk edges, rd_level=1.
- Same nibbles in little-endian -> q=32'h87654321. 8-bit mode, bytes A5,5A,FF,00, big-endian -> q=32'hA55AFF00.
- 1-bit mode, 32 beats of alternating 1,0 starting with 1, big-endian -> q=32'hAAAAAAAA.
- 4-bit big-endian, nibbles 9,C,3 then flush -> q=32'h9C300000; a following full word is stored separately.
- DEPTH=16: write 17 words with no reads -> full after the 16th, overflow=1 after the 17th. Read 16 words -> values in order with an exact wrap, then empty=1. overflow stays 1 until rst.
- Unrelated clocks (wclk 50 MHz, rclk 33 MHz), 1000 random words, random rd gaps, rst pulsed mid-stream -> no loss or duplication before the rst pulse. All flags/levels at reset values after the pulse. Stream restarts cleanly.
